// File: rtl/bram_port_arbiter_if.sv
// Bus bundle for bram_port_arbiter: two byte-wide requester ports (A/B)
// plus the 32-bit BRAM-facing write/read bus.
interface bram_port_arbiter_if;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BRAM_AW = 8;
  localparam int unsigned BRAM_DW = 32;
  localparam int unsigned CFG_W   = 6;

  logic                a_req;
  logic                a_we;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_wdata;
  logic                a_gnt;
  logic                a_rvalid;
  logic [DATA_W-1:0]   a_rdata;

  logic                b_req;
  logic                b_we;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_wdata;
  logic                b_gnt;
  logic                b_rvalid;
  logic [DATA_W-1:0]   b_rdata;

  logic [BRAM_AW-1:0]  bram_wr_addr;
  logic [BRAM_DW-1:0]  bram_wr_data;
  logic [BRAM_AW-1:0]  bram_rd_addr;
  logic [BRAM_DW-1:0]  bram_rd_data;
  logic [CFG_W-1:0]    bram_cfg;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  bram_rd_data,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output bram_wr_addr, bram_wr_data, bram_rd_addr, bram_cfg
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output bram_rd_data,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  bram_wr_addr, bram_wr_data, bram_rd_addr, bram_cfg
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM (8-bit write / 8-bit read, data-driven write enable) between
// two requesters with independent round-robin write and read arbitration.
module bram_port_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                clk,
  input logic                resetn,
  bram_port_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BRAM_AW = 8;
  localparam int unsigned BRAM_DW = 32;
  // Only 1 and 2 are meaningful; anything else behaves as 1.
  localparam int unsigned LAT     = (READ_LATENCY == 2) ? 2 : 1;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  src_e               r_wr_last;
  src_e               r_rd_last;
  logic [LAT-1:0]     r_pipe_vld;
  src_e               r_pipe_id [LAT];

  logic               w_wr_cand_a;
  logic               w_wr_cand_b;
  logic               w_rd_cand_a;
  logic               w_rd_cand_b;
  src_e               w_wr_sel;
  src_e               w_rd_sel;
  logic               w_wr_go;
  logic               w_rd_go;
  logic               w_hazard;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0]  w_wr_byte;
  logic [BRAM_DW-1:0] w_bram_wr_data;
  logic               w_ret_vld;
  src_e               w_ret_id;
  logic               w_a_rvalid;
  logic               w_b_rvalid;
  logic               w_unused_rd_hi;

  // Per-port arbitration; a read that collides with this cycle's write waits.
  always_comb begin : arb
    w_wr_cand_a = bus.a_req & bus.a_we;
    w_wr_cand_b = bus.b_req & bus.b_we;
    w_rd_cand_a = bus.a_req & ~bus.a_we;
    w_rd_cand_b = bus.b_req & ~bus.b_we;

    w_wr_sel = SRC_A;
    if (w_wr_cand_a && w_wr_cand_b) begin
      w_wr_sel = (r_wr_last == SRC_A) ? SRC_B : SRC_A;
    end else if (w_wr_cand_b) begin
      w_wr_sel = SRC_B;
    end

    w_rd_sel = SRC_A;
    if (w_rd_cand_a && w_rd_cand_b) begin
      w_rd_sel = (r_rd_last == SRC_A) ? SRC_B : SRC_A;
    end else if (w_rd_cand_b) begin
      w_rd_sel = SRC_B;
    end

    w_wr_addr = (w_wr_sel == SRC_A) ? bus.a_addr  : bus.b_addr;
    w_wr_byte = (w_wr_sel == SRC_A) ? bus.a_wdata : bus.b_wdata;
    w_rd_addr = (w_rd_sel == SRC_A) ? bus.a_addr  : bus.b_addr;

    w_wr_go  = resetn & (w_wr_cand_a | w_wr_cand_b);
    w_hazard = w_wr_go & (w_rd_addr == w_wr_addr);
    w_rd_go  = resetn & (w_rd_cand_a | w_rd_cand_b) & ~w_hazard;
  end

  // BRAM write word carries both the write byte and the upper address bits.
  always_comb begin : bram_word
    w_bram_wr_data = '0;
    if (w_wr_go) begin
      w_bram_wr_data[7:0]   = w_wr_byte;
      w_bram_wr_data[17:16] = w_wr_addr[ADDR_W-1:BRAM_AW];
      w_bram_wr_data[20]    = 1'b1;
    end
    if (w_rd_go) begin
      w_bram_wr_data[25:24] = w_rd_addr[ADDR_W-1:BRAM_AW];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin : rr_ptrs
    if (!resetn) begin
      r_wr_last <= SRC_B;
      r_rd_last <= SRC_B;
    end else begin
      if (w_wr_go) r_wr_last <= w_wr_sel;
      if (w_rd_go) r_rd_last <= w_rd_sel;
    end
  end

  // Return tracker: one {valid, id} slot per cycle of BRAM read latency.
  always_ff @(posedge clk or negedge resetn) begin : ret_pipe
    if (!resetn) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < int'(LAT); i++) r_pipe_id[i] <= SRC_A;
    end else begin
      r_pipe_vld[0] <= w_rd_go;
      r_pipe_id[0]  <= w_rd_sel;
      for (int i = 1; i < int'(LAT); i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  assign w_ret_vld  = r_pipe_vld[LAT-1];
  assign w_ret_id   = r_pipe_id[LAT-1];
  assign w_a_rvalid = w_ret_vld & (w_ret_id == SRC_A);
  assign w_b_rvalid = w_ret_vld & (w_ret_id == SRC_B);

  assign bus.a_gnt        = (w_wr_go & (w_wr_sel == SRC_A)) | (w_rd_go & (w_rd_sel == SRC_A));
  assign bus.b_gnt        = (w_wr_go & (w_wr_sel == SRC_B)) | (w_rd_go & (w_rd_sel == SRC_B));
  assign bus.bram_wr_addr = w_wr_go ? w_wr_addr[BRAM_AW-1:0] : '0;
  assign bus.bram_rd_addr = w_rd_go ? w_rd_addr[BRAM_AW-1:0] : '0;
  assign bus.bram_wr_data = w_bram_wr_data;
  assign bus.a_rvalid     = w_a_rvalid;
  assign bus.b_rvalid     = w_b_rvalid;
  assign bus.a_rdata      = w_a_rvalid ? bus.bram_rd_data[DATA_W-1:0] : '0;
  assign bus.b_rdata      = w_b_rvalid ? bus.bram_rd_data[DATA_W-1:0] : '0;
  assign bus.bram_cfg     = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (READ_LATENCY == 2)};

  // Upper read-word bits carry nothing in 8-bit read mode.
  assign w_unused_rd_hi = ^bus.bram_rd_data[BRAM_DW-1:DATA_W];
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: latency-1 and latency-2 instances share stimulus,
// each backed by a small BRAM model, checked against a queue-based reference.
module tb_bram_port_arbiter;
  logic       clk = 1'b0;
  logic       resetn;
  logic       a_req, a_we, b_req, b_we;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  bram_port_arbiter_if bif1 ();
  bram_port_arbiter_if bif2 ();

  bram_port_arbiter #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(bif1));
  bram_port_arbiter #(.READ_LATENCY(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bif2));

  always #5 clk = ~clk;

  assign bif1.a_req = a_req;  assign bif1.a_we = a_we;  assign bif1.a_addr = a_addr;  assign bif1.a_wdata = a_wdata;
  assign bif1.b_req = b_req;  assign bif1.b_we = b_we;  assign bif1.b_addr = b_addr;  assign bif1.b_wdata = b_wdata;
  assign bif2.a_req = a_req;  assign bif2.a_we = a_we;  assign bif2.a_addr = a_addr;  assign bif2.a_wdata = a_wdata;
  assign bif2.b_req = b_req;  assign bif2.b_we = b_we;  assign bif2.b_addr = b_addr;  assign bif2.b_wdata = b_wdata;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  // BRAM models: 1024 bytes addressed by {embedded addr[9:8], 8-bit port address}
  logic [7:0] mem1 [1024];
  logic [7:0] mem2 [1024];
  logic [7:0] q1, q2a, q2b;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= pat(i);
      q1 <= 8'h00;
    end else begin
      if (bif1.bram_wr_data[20]) mem1[{bif1.bram_wr_data[17:16], bif1.bram_wr_addr}] <= bif1.bram_wr_data[7:0];
      q1 <= mem1[{bif1.bram_wr_data[25:24], bif1.bram_rd_addr}];
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 1024; i++) mem2[i] <= pat(i);
      q2a <= 8'h00;
      q2b <= 8'h00;
    end else begin
      if (bif2.bram_wr_data[20]) mem2[{bif2.bram_wr_data[17:16], bif2.bram_wr_addr}] <= bif2.bram_wr_data[7:0];
      q2a <= mem2[{bif2.bram_wr_data[25:24], bif2.bram_rd_addr}];
      q2b <= q2a;
    end
  end

  assign bif1.bram_rd_data = {24'hC3A5F0, q1};
  assign bif2.bram_rd_data = {24'h5A0FE1, q2b};

  wire [67:0] obs1 = {bif1.a_gnt, bif1.b_gnt, bif1.a_rvalid, bif1.b_rvalid, bif1.a_rdata, bif1.b_rdata,
                      bif1.bram_wr_addr, bif1.bram_rd_addr, bif1.bram_wr_data};
  wire [67:0] obs2 = {bif2.a_gnt, bif2.b_gnt, bif2.a_rvalid, bif2.b_rvalid, bif2.a_rdata, bif2.b_rdata,
                      bif2.bram_wr_addr, bif2.bram_rd_addr, bif2.bram_wr_data};

  // Reference model: requester ids 0 = A, 1 = B; returns scheduled by due cycle
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } ret_t;

  ret_t       rq1[$];
  ret_t       rq2[$];
  logic [7:0] ref_mem [1024];
  int         m_wr_last = 1;
  int         m_rd_last = 1;
  int         cyc = 0;
  bit         e_wr_go, e_rd_go;
  int         e_wr_id, e_rd_id;
  logic [9:0] e_wa, e_ra;
  logic [7:0] e_wd;
  logic       e_a_gnt, e_b_gnt;
  logic [67:0] exp1, exp2;

  function automatic void model_eval();
    logic       rq [2];
    logic       we [2];
    logic [9:0] ad [2];
    logic [7:0] wd [2];
    int         wc[$];
    int         rc[$];
    int         cand;
    logic [31:0] word;
    logic       ga, gb, rv1a, rv1b, rv2a, rv2b;
    logic [7:0] rd1a, rd1b, rd2a, rd2b;
    rq[0] = a_req;  we[0] = a_we;  ad[0] = a_addr;  wd[0] = a_wdata;
    rq[1] = b_req;  we[1] = b_we;  ad[1] = b_addr;  wd[1] = b_wdata;
    e_wr_go = 0; e_rd_go = 0; e_wr_id = 0; e_rd_id = 0;
    word = 32'h0; ga = 0; gb = 0;
    rv1a = 0; rv1b = 0; rv2a = 0; rv2b = 0;
    rd1a = 8'h00; rd1b = 8'h00; rd2a = 8'h00; rd2b = 8'h00;
    for (int i = 0; i < 2; i++) begin
      if (rq[i] && we[i])  wc.push_back(i);
      if (rq[i] && !we[i]) rc.push_back(i);
    end
    if (resetn && wc.size() > 0) begin
      e_wr_go = 1;
      e_wr_id = (wc.size() == 2) ? 1 - m_wr_last : wc[0];
    end
    if (resetn && rc.size() > 0) begin
      cand = (rc.size() == 2) ? 1 - m_rd_last : rc[0];
      if (!(e_wr_go && ad[cand] == ad[e_wr_id])) begin
        e_rd_go = 1;
        e_rd_id = cand;
      end
    end
    e_wa = ad[e_wr_id];
    e_wd = wd[e_wr_id];
    e_ra = ad[e_rd_id];
    if (e_wr_go) begin
      word = word + 32'(e_wd) + 32'(e_wa / 256) * 32'h10000 + 32'h100000;
      if (e_wr_id == 0) ga = 1; else gb = 1;
    end
    if (e_rd_go) begin
      word = word + 32'(e_ra / 256) * 32'h1000000;
      if (e_rd_id == 0) ga = 1; else gb = 1;
    end
    if (resetn && rq1.size() > 0 && rq1[0].due == cyc) begin
      if (rq1[0].id == 0) begin rv1a = 1; rd1a = rq1[0].data; end
      else begin rv1b = 1; rd1b = rq1[0].data; end
    end
    if (resetn && rq2.size() > 0 && rq2[0].due == cyc) begin
      if (rq2[0].id == 0) begin rv2a = 1; rd2a = rq2[0].data; end
      else begin rv2b = 1; rd2b = rq2[0].data; end
    end
    e_a_gnt = ga;
    e_b_gnt = gb;
    exp1 = {ga, gb, rv1a, rv1b, rd1a, rd1b, (e_wr_go ? e_wa[7:0] : 8'h00), (e_rd_go ? e_ra[7:0] : 8'h00), word};
    exp2 = {ga, gb, rv2a, rv2b, rd2a, rd2b, (e_wr_go ? e_wa[7:0] : 8'h00), (e_rd_go ? e_ra[7:0] : 8'h00), word};
  endfunction

  task automatic model_tick();
    logic [7:0] rdv;
    if (!resetn) begin
      rq1.delete();
      rq2.delete();
      m_wr_last = 1;
      m_rd_last = 1;
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    end else begin
      if (rq1.size() > 0 && rq1[0].due == cyc) void'(rq1.pop_front());
      if (rq2.size() > 0 && rq2[0].due == cyc) void'(rq2.pop_front());
      rdv = ref_mem[e_ra];
      if (e_wr_go) begin
        ref_mem[e_wa] = e_wd;
        m_wr_last = e_wr_id;
      end
      if (e_rd_go) begin
        rq1.push_back('{due: cyc + 1, id: e_rd_id, data: rdv});
        rq2.push_back('{due: cyc + 2, id: e_rd_id, data: rdv});
        m_rd_last = e_rd_id;
      end
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic set_a(input logic r, input logic w, input logic [9:0] ad, input logic [7:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [9:0] ad, input logic [7:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 10'h000, 8'h00);
    set_b(1'b0, 1'b0, 10'h000, 8'h00);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_a(1'b1, 1'b1, 10'h3FF, 8'hFF);
    set_b(1'b1, 1'b0, 10'h001, 8'h00);
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if (obs1 !== 68'h0) begin n_fail++; $display("FAIL reset_outputs_rl1: got %h, expected 0", obs1); end
      n_checks++;
      if (obs2 !== 68'h0) begin n_fail++; $display("FAIL reset_outputs_rl2: got %h, expected 0", obs2); end
      advance();
    end
    n_checks++;
    if (bif1.bram_cfg !== 6'b101000) begin n_fail++; $display("FAIL cfg_rl1: got %b, expected 101000", bif1.bram_cfg); end
    n_checks++;
    if (bif2.bram_cfg !== 6'b101001) begin n_fail++; $display("FAIL cfg_rl2: got %b, expected 101001", bif2.bram_cfg); end
    idle();
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    set_a(1'b1, 1'b1, 10'h2A5, 8'h5C);
    settle();
    n_checks++;
    if ({bif1.a_gnt, bif1.b_gnt} !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b, expected 10", {bif1.a_gnt, bif1.b_gnt}); end
    n_checks++;
    if (bif1.bram_wr_addr !== 8'hA5) begin n_fail++; $display("FAIL wr_addr: got %h, expected a5", bif1.bram_wr_addr); end
    n_checks++;
    if (bif1.bram_wr_data !== 32'h0012005C) begin n_fail++; $display("FAIL wr_data: got %h, expected 0012005c", bif1.bram_wr_data); end
    advance();
    set_a(1'b0, 1'b0, 10'h000, 8'h00);
    set_b(1'b1, 1'b0, 10'h2A5, 8'h00);
    settle();
    n_checks++;
    if ({bif1.a_gnt, bif1.b_gnt} !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b, expected 01", {bif1.a_gnt, bif1.b_gnt}); end
    n_checks++;
    if (bif1.bram_rd_addr !== 8'hA5) begin n_fail++; $display("FAIL rd_addr: got %h, expected a5", bif1.bram_rd_addr); end
    n_checks++;
    if (bif1.bram_wr_data !== 32'h02000000) begin n_fail++; $display("FAIL rd_word: got %h, expected 02000000", bif1.bram_wr_data); end
    advance();
    idle();
    settle();
    n_checks++;
    if ({bif1.b_rvalid, bif1.b_rdata} !== 9'h15C) begin n_fail++; $display("FAIL rd_ret_rl1: got %h, expected 15c", {bif1.b_rvalid, bif1.b_rdata}); end
    n_checks++;
    if ({bif2.b_rvalid, bif2.b_rdata} !== 9'h000) begin n_fail++; $display("FAIL rd_early_rl2: got %h, expected 000", {bif2.b_rvalid, bif2.b_rdata}); end
    advance();
    settle();
    n_checks++;
    if ({bif1.b_rvalid, bif1.b_rdata} !== 9'h000) begin n_fail++; $display("FAIL rd_pulse_rl1: got %h, expected 000", {bif1.b_rvalid, bif1.b_rdata}); end
    n_checks++;
    if ({bif2.b_rvalid, bif2.b_rdata} !== 9'h15C) begin n_fail++; $display("FAIL rd_ret_rl2: got %h, expected 15c", {bif2.b_rvalid, bif2.b_rdata}); end
    advance();
  endtask

  task automatic test_rr_writes();
    do_reset();
    set_a(1'b1, 1'b1, 10'h100, 8'h11);
    set_b(1'b1, 1'b1, 10'h200, 8'h22);
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  eg;
      logic [31:0] ew;
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      ew = (k % 2 == 0) ? 32'h00110011 : 32'h00120022;
      settle();
      n_checks++;
      if ({bif1.a_gnt, bif1.b_gnt} !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b, expected %b", k, {bif1.a_gnt, bif1.b_gnt}, eg); end
      n_checks++;
      if (bif2.bram_wr_data !== ew) begin n_fail++; $display("FAIL rr_word[%0d]: got %h, expected %h", k, bif2.bram_wr_data, ew); end
      advance();
    end
    idle();
  endtask

  task automatic test_hazard();
    logic [7:0] d;
    d = 8'($urandom);
    set_a(1'b1, 1'b1, 10'h010, d);
    set_b(1'b1, 1'b0, 10'h010, 8'h00);
    settle();
    n_checks++;
    if ({bif1.a_gnt, bif1.b_gnt} !== 2'b10) begin n_fail++; $display("FAIL hz_gnt: got %b, expected 10", {bif1.a_gnt, bif1.b_gnt}); end
    n_checks++;
    if (bif1.bram_wr_data !== (32'h00100000 | 32'(d))) begin n_fail++; $display("FAIL hz_word: got %h, expected %h", bif1.bram_wr_data, 32'h00100000 | 32'(d)); end
    advance();
    set_a(1'b0, 1'b0, 10'h000, 8'h00);
    settle();
    n_checks++;
    if ({bif1.b_gnt, bif1.bram_rd_addr} !== 9'h110) begin n_fail++; $display("FAIL hz_retry: got %h, expected 110", {bif1.b_gnt, bif1.bram_rd_addr}); end
    advance();
    idle();
    settle();
    n_checks++;
    if ({bif1.b_rvalid, bif1.b_rdata} !== {1'b1, d}) begin n_fail++; $display("FAIL hz_data_rl1: got %h, expected %h", {bif1.b_rvalid, bif1.b_rdata}, {1'b1, d}); end
    advance();
    settle();
    n_checks++;
    if ({bif2.b_rvalid, bif2.b_rdata} !== {1'b1, d}) begin n_fail++; $display("FAIL hz_data_rl2: got %h, expected %h", {bif2.b_rvalid, bif2.b_rdata}, {1'b1, d}); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [9:0] ad [3];
    logic [7:0] ed [3];
    for (int i = 0; i < 3; i++) begin
      ad[i] = 10'($urandom);
      ed[i] = ref_mem[ad[i]];
    end
    set_b(1'b0, 1'b0, 10'h000, 8'h00);
    for (int k = 0; k < 6; k++) begin
      logic [8:0] x1, x2;
      if (k < 3) set_a(1'b1, 1'b0, ad[k], 8'h00);
      else       set_a(1'b0, 1'b0, 10'h000, 8'h00);
      x1 = (k >= 1 && k <= 3) ? {1'b1, ed[k-1]} : 9'h000;
      x2 = (k >= 2 && k <= 4) ? {1'b1, ed[k-2]} : 9'h000;
      settle();
      if (k < 3) begin
        n_checks++;
        if (bif2.a_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b, expected 1", k, bif2.a_gnt); end
      end
      n_checks++;
      if ({bif1.a_rvalid, bif1.a_rdata} !== x1) begin n_fail++; $display("FAIL b2b_rl1[%0d]: got %h, expected %h", k, {bif1.a_rvalid, bif1.a_rdata}, x1); end
      n_checks++;
      if ({bif2.a_rvalid, bif2.a_rdata} !== x2) begin n_fail++; $display("FAIL b2b_rl2[%0d]: got %h, expected %h", k, {bif2.a_rvalid, bif2.a_rdata}, x2); end
      advance();
    end
  endtask

  task automatic test_reset_drop();
    set_a(1'b1, 1'b0, 10'($urandom), 8'h00);
    settle();
    n_checks++;
    if (bif1.a_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_gnt: got %b, expected 1", bif1.a_gnt); end
    advance();
    resetn = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if (obs1 !== 68'h0) begin n_fail++; $display("FAIL drop_rst_rl1[%0d]: got %h, expected 0", k, obs1); end
      n_checks++;
      if (obs2 !== 68'h0) begin n_fail++; $display("FAIL drop_rst_rl2[%0d]: got %h, expected 0", k, obs2); end
      advance();
    end
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++;
      if ({bif1.a_rvalid, bif1.b_rvalid, bif2.a_rvalid, bif2.b_rvalid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL drop_rvalid[%0d]: got %b, expected 0000", k, {bif1.a_rvalid, bif1.b_rvalid, bif2.a_rvalid, bif2.b_rvalid});
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic a_took, b_took;
    a_took = 1'b0;
    b_took = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_req || a_took) begin
        a_req   = ($urandom_range(0, 3) != 0);
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = {2'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7))};
        a_wdata = 8'($urandom);
      end
      if (!b_req || b_took) begin
        b_req   = ($urandom_range(0, 3) != 0);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = {2'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7))};
        b_wdata = 8'($urandom);
      end
      settle();
      n_checks++;
      if (obs1 !== exp1) begin n_fail++; $display("FAIL rand_rl1[%0d]: got %h, expected %h", c, obs1, exp1); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL rand_rl2[%0d]: got %h, expected %h", c, obs2, exp2); end
      a_took = e_a_gnt;
      b_took = e_b_gnt;
      advance();
    end
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_rr_writes();
    test_hazard();
    test_back_to_back();
    test_reset_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
